// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg
//   Shared types and helpers for the clock divider controller.
//   - state_e    : controller states (IDLE, RUN, PEND)
//   - clamp_half : maps a requested half-period of 0 to 1
package clock_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_e;

  // Wide enough for any supported WIDTH (<= 32); callers cast in and out.
  localparam int unsigned CLAMP_W = 32;

  function automatic logic [CLAMP_W-1:0] clamp_half(input logic [CLAMP_W-1:0] half);
    return (half == '0) ? CLAMP_W'(1) : half;
  endfunction

endpackage

// File: rtl/clock_divider_controller_counter.sv
// divider_counter
//   Period counter with rollover compare for the clock divider controller.
//   Ports:
//     clk       in  : system clock
//     reset_n   in  : asynchronous active-low reset
//     run       in  : count this cycle (controller running and enabled)
//     load_zero in  : force the counter back to 0
//     half      in  : half-period H currently in effect (>= 1)
//     rollover  out : counter is at H-1 and returns to 0 on this edge
module divider_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             load_zero,
  input  logic [WIDTH-1:0] half,
  output logic             rollover
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] last_q_val;

  // H >= 1 is guaranteed upstream, so H-1 never underflows and the counter
  // never exceeds H-1.
  assign last_q_val = half - WIDTH'(1);
  assign rollover   = run && !load_zero && (count_q == last_q_val);

  always_comb begin
    count_d = count_q + WIDTH'(1);
    if (load_zero || !run || rollover) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/clock_divider_controller.sv
// clock_divider_controller
//   Runtime-programmable clock-enable generator. A half-period H is loaded
//   over a valid/ready handshake and only takes effect at a period boundary,
//   so tick spacing and the divided clock never glitch.
//   Optional feature macro: CLOCK_DIVIDER_CONTROLLER_CLK_OUT_EN
//     defined   -> clk_out port (50% duty, period 2H) is present
//     undefined -> only tick is produced
//   Ports:
//     clk       in  : system clock
//     reset_n   in  : asynchronous active-low reset
//     enable    in  : run request; low forces IDLE
//     cfg_valid in  : new half-period offered
//     cfg_half  in  : requested half-period (0 is treated as 1)
//     cfg_ready out : config accepted this cycle (low while a change is pending)
//     tick      out : one-cycle pulse every H cycles while running
//     clk_out   out : divided clock (macro only)
//     running   out : high in RUN or PEND
//     cur_half  out : half-period currently in effect
//
//   state | meaning
//   IDLE  | stopped; counter held at 0, config writes active value directly
//   RUN   | counting with the active half-period
//   PEND  | counting; a new half-period waits in the shadow for the next rollover
module clock_divider_controller
  import clock_divider_pkg::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned DEFAULT_HALF = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             tick,
`ifdef CLOCK_DIVIDER_CONTROLLER_CLK_OUT_EN
  output logic             clk_out,
`endif
  output logic             running,
  output logic [WIDTH-1:0] cur_half
);

  localparam logic [WIDTH-1:0] RESET_HALF = WIDTH'(DEFAULT_HALF);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             tick_q;
  logic             run;
  logic             rollover;
  logic             xfer;
  logic [WIDTH-1:0] half_clamped;

  assign run          = enable && (state_q != IDLE);
  assign cfg_ready    = (state_q != PEND);
  assign xfer         = cfg_valid && cfg_ready;
  assign half_clamped = WIDTH'(clamp_half(CLAMP_W'(cfg_half)));

  divider_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .load_zero(!enable),
    .half     (active_q),
    .rollover (rollover)
  );

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (xfer) active_d = half_clamped;
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) begin
          // A config accepted on the stop edge goes straight to the active value.
          state_d = IDLE;
          if (xfer) active_d = half_clamped;
        end else if (xfer) begin
          // A rollover on this same edge still uses the old H.
          shadow_d = half_clamped;
          state_d  = PEND;
        end
      end
      PEND: begin
        if (!enable) begin
          state_d  = IDLE;
          active_d = shadow_q;
        end else if (rollover) begin
          active_d = shadow_q;
          state_d  = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      active_q <= RESET_HALF;
      shadow_q <= RESET_HALF;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
      tick_q   <= rollover;
    end
  end

`ifdef CLOCK_DIVIDER_CONTROLLER_CLK_OUT_EN
  logic clk_out_q, clk_out_d;

  assign clk_out_d = run ? (clk_out_q ^ rollover) : 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_out_q <= 1'b0;
    end else begin
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;
`endif

  assign tick     = tick_q;
  assign running  = (state_q != IDLE);
  assign cur_half = active_q;

endmodule

// File: tb/tb_clock_divider_controller.sv
module tb_clock_divider_controller;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        cfg_valid;
  logic [15:0] cfg_half;
  logic        cfg_ready;
  logic        tick;
`ifdef CLOCK_DIVIDER_CONTROLLER_CLK_OUT_EN
  logic        clk_out;
`endif
  logic        running;
  logic [15:0] cur_half;

  int total = 0;
  int bad   = 0;

  // Reference model: elapsed cycles in the current period, period length,
  // optional pending period length.
  bit m_run, m_pend, m_tick, m_clk;
  int m_h, m_shadow, m_elapsed;

  clock_divider_controller #(.WIDTH(16), .DEFAULT_HALF(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .cfg_valid(cfg_valid),
    .cfg_half (cfg_half),
    .cfg_ready(cfg_ready),
    .tick     (tick),
`ifdef CLOCK_DIVIDER_CONTROLLER_CLK_OUT_EN
    .clk_out  (clk_out),
`endif
    .running  (running),
    .cur_half (cur_half)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_tick = 0; m_clk = 0;
    m_h = 2; m_shadow = 2; m_elapsed = 0;
  endtask

  task automatic model_edge();
    bit xfer;
    int h;
    if (!reset_n) begin
      model_reset();
      return;
    end
    xfer = cfg_valid && !m_pend;
    h = (cfg_half == 16'd0) ? 1 : int'(cfg_half);
    if (!m_run) begin
      if (xfer) m_h = h;
      m_tick = 0; m_clk = 0; m_elapsed = 0;
      if (enable) m_run = 1;
    end else if (!enable) begin
      if (m_pend) m_h = m_shadow;
      else if (xfer) m_h = h;
      m_run = 0; m_pend = 0; m_tick = 0; m_clk = 0; m_elapsed = 0;
    end else begin
      m_elapsed++;
      m_tick = (m_elapsed == m_h);
      if (m_tick) begin
        m_elapsed = 0;
        m_clk = !m_clk;
        if (m_pend) begin
          m_h = m_shadow;
          m_pend = 0;
        end
      end
      if (xfer) begin
        m_shadow = h;
        m_pend = 1;
      end
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic load_idle(input int h);
    enable = 0; cfg_valid = 0;
    edge_step();
    cfg_valid = 1; cfg_half = 16'(h);
    edge_step();
    cfg_valid = 0;
  endtask

  task automatic wait_tick();
    bit got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      edge_step();
      if (tick) got = 1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL wait_tick: tick=%0b after 40 cycles, required 1", tick);
    end
  endtask

  task automatic test_reset();
    reset_n = 0; enable = 0; cfg_valid = 0; cfg_half = 0;
    model_reset();
    edge_step();
    edge_step();
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %0b want 0", tick); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %0b want 1", cfg_ready); end
    total++; if (running !== 1'b0) begin bad++; $display("FAIL reset_running: got %0b want 0", running); end
    total++; if (cur_half !== 16'd2) begin bad++; $display("FAIL reset_cur_half: got %0d want 2", cur_half); end
`ifdef CLOCK_DIVIDER_CONTROLLER_CLK_OUT_EN
    total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL reset_clk_out: got %0b want 0", clk_out); end
`endif
  endtask

  task automatic test_default_timing();
    bit exp_tick, exp_clk;
    reset_n = 1;
    for (int e = 1; e <= 4; e++) edge_step();
    total++; if (running !== 1'b0 || tick !== 1'b0) begin
      bad++; $display("FAIL idle_hold: running=%0b tick=%0b want 0 0", running, tick);
    end
    enable = 1;
    edge_step();
    total++; if (running !== 1'b1 || tick !== 1'b0) begin
      bad++; $display("FAIL enable_edge: running=%0b tick=%0b want 1 0", running, tick);
    end
    for (int i = 1; i <= 7; i++) begin
      edge_step();
      exp_tick = (i % 2 == 0);
      exp_clk  = ((i / 2) % 2 == 1);
      total++; if (tick !== exp_tick) begin
        bad++; $display("FAIL default_tick[%0d]: got %0b want %0b", i, tick, exp_tick);
      end
`ifdef CLOCK_DIVIDER_CONTROLLER_CLK_OUT_EN
      total++; if (clk_out !== exp_clk) begin
        bad++; $display("FAIL default_clk_out[%0d]: got %0b want %0b", i, clk_out, exp_clk);
      end
`else
      if (exp_clk) begin end
`endif
    end
  endtask

  task automatic test_reconfig_run();
    bit exp_tick, exp_ready;
    int exp_cur;
    load_idle(3);
    enable = 1;
    edge_step();
    wait_tick();
    cfg_valid = 1; cfg_half = 16'd5;
    edge_step();
    cfg_valid = 0;
    total++; if (cfg_ready !== 1'b0 || tick !== 1'b0 || cur_half !== 16'd3) begin
      bad++; $display("FAIL capture_edge: ready=%0b tick=%0b cur=%0d want 0 0 3", cfg_ready, tick, cur_half);
    end
    for (int j = 1; j <= 12; j++) begin
      edge_step();
      exp_tick  = (j == 2) || (j == 7) || (j == 12);
      exp_ready = (j >= 2);
      exp_cur   = (j >= 2) ? 5 : 3;
      total++; if (tick !== exp_tick || cfg_ready !== exp_ready || cur_half !== 16'(exp_cur)) begin
        bad++;
        $display("FAIL reconfig[%0d]: tick=%0b ready=%0b cur=%0d want %0b %0b %0d",
                 j, tick, cfg_ready, cur_half, exp_tick, exp_ready, exp_cur);
      end
    end
  endtask

  task automatic test_clamp_zero();
    load_idle(0);
    total++; if (cur_half !== 16'd1) begin bad++; $display("FAIL clamp_cur_half: got %0d want 1", cur_half); end
    enable = 1;
    edge_step();
    for (int i = 1; i <= 4; i++) begin
      edge_step();
      total++; if (tick !== 1'b1) begin bad++; $display("FAIL clamp_tick[%0d]: got %0b want 1", i, tick); end
    end
  endtask

  task automatic test_pend_drop();
    load_idle(4);
    enable = 1;
    edge_step();
    edge_step();
    edge_step();
    cfg_valid = 1; cfg_half = 16'd7;
    edge_step();
    cfg_valid = 0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL pend_ready: got %0b want 0", cfg_ready); end
    enable = 0;
    edge_step();
    total++; if (tick !== 1'b0 || running !== 1'b0 || cur_half !== 16'd7 || cfg_ready !== 1'b1) begin
      bad++; $display("FAIL pend_drop: tick=%0b running=%0b cur=%0d ready=%0b want 0 0 7 1",
                      tick, running, cur_half, cfg_ready);
    end
`ifdef CLOCK_DIVIDER_CONTROLLER_CLK_OUT_EN
    total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL pend_drop_clk_out: got %0b want 0", clk_out); end
`endif
  endtask

  task automatic test_async_reset();
    // H is 7 from the previous scenario.
    enable = 1;
    edge_step();
    wait_tick();
    edge_step();
    edge_step();
    edge_step();
    #2 reset_n = 0;
    model_reset();
    #1;
    total++; if (tick !== 1'b0 || running !== 1'b0 || cfg_ready !== 1'b1 || cur_half !== 16'd2) begin
      bad++; $display("FAIL async_reset: tick=%0b running=%0b ready=%0b cur=%0d want 0 0 1 2",
                      tick, running, cfg_ready, cur_half);
    end
`ifdef CLOCK_DIVIDER_CONTROLLER_CLK_OUT_EN
    total++; if (clk_out !== 1'b0) begin bad++; $display("FAIL async_reset_clk_out: got %0b want 0", clk_out); end
`endif
    edge_step();
    edge_step();
    reset_n = 1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      enable    = ($urandom_range(0, 11) != 0);
      cfg_valid = ($urandom_range(0, 4) == 0);
      cfg_half  = 16'($urandom_range(0, 7));
      edge_step();
      total++;
      if (tick !== m_tick || cfg_ready !== !m_pend || running !== m_run || cur_half !== 16'(m_h)) begin
        bad++;
        $display("FAIL random[%0d]: tick=%0b ready=%0b running=%0b cur=%0d want %0b %0b %0b %0d",
                 c, tick, cfg_ready, running, cur_half, m_tick, !m_pend, m_run, m_h);
      end
`ifdef CLOCK_DIVIDER_CONTROLLER_CLK_OUT_EN
      total++;
      if (clk_out !== m_clk) begin
        bad++; $display("FAIL random_clk_out[%0d]: got %0b want %0b", c, clk_out, m_clk);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_default_timing();
    test_reconfig_run();
    test_clamp_zero();
    test_pend_drop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
